// File: rtl/intr_stim_pkg.sv
// Shared encodings and helpers for the interrupt stimulus generator.
package intr_stim_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_RANDOM   = 2'd2,
    MODE_ACK      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
  // Golden-ratio constant used to spread the base seed across channels.
  localparam logic [31:0] SEED_SPREAD = 32'h9E3779B9;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] ch_seed(input logic [31:0] base, input int unsigned ch);
    logic [31:0] s;
    s = base ^ (32'(ch) * SEED_SPREAD);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/intr_stim_ch.sv
// One interrupt stimulus channel: free-running LFSR, delay/hold counter and FSM.
module intr_stim_ch
  import intr_stim_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DLY_MIN   = 10,
  parameter int unsigned SPAN_LOG2 = 7,
  parameter int unsigned HOLD_CYC  = 80,
  parameter int unsigned PERIOD    = 200,
  parameter logic [31:0] CH_SEED   = 32'h00003039
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [1:0] mode_i,
  input  logic       ack_i,
  output logic       intr_o,
  output logic       fire_o,
  output logic       busy_o
);

  localparam logic [31:0] SpanMask =
      (SPAN_LOG2 >= 32) ? 32'hFFFF_FFFF : ((32'd1 << SPAN_LOG2) - 32'd1);
  localparam logic [CNT_W-1:0] DlyLd  = CNT_W'(DLY_MIN);
  localparam logic [CNT_W-1:0] HoldLd = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] PerLd  = CNT_W'(PERIOD);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic             intr_q, intr_d;
  logic [CNT_W-1:0] rand_dly;

  assign rand_dly = DlyLd + CNT_W'(lfsr_q & SpanMask);

  // Next-state: LFSR always advances; enable low parks the channel in IDLE.
  always_comb begin
    lfsr_d  = lfsr_next(lfsr_q);
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    intr_d  = intr_q;
    fire_o  = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      intr_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          mode_d  = mode_e'(mode_i);
          state_d = ST_WAIT;
          cnt_d   = (mode_e'(mode_i) == MODE_PERIODIC) ? DlyLd : rand_dly;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_d = ST_ASSERT;
            intr_d  = 1'b1;
            cnt_d   = HoldLd;
            fire_o  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_ASSERT: begin
          if (mode_q == MODE_ACK) begin
            if (ack_i) begin
              intr_d  = 1'b0;
              state_d = ST_WAIT;
              cnt_d   = rand_dly;
            end
          end else if (cnt_q == '0) begin
            intr_d = 1'b0;
            if (mode_q == MODE_ONESHOT) begin
              state_d = ST_DONE;
            end else if (mode_q == MODE_PERIODIC) begin
              state_d = ST_WAIT;
              cnt_d   = PerLd;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = rand_dly;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset clears the line asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      cnt_q   <= '0;
      lfsr_q  <= CH_SEED;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      intr_q  <= intr_d;
    end
  end

  assign intr_o = intr_q;
  assign busy_o = (state_q == ST_WAIT) || (state_q == ST_ASSERT);

endmodule

// File: rtl/intr_stim_gen.sv
// Multi-channel external-interrupt stimulus generator with a shared fire counter.
module intr_stim_gen
  import intr_stim_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DLY_MIN   = 10,
  parameter int unsigned SPAN_LOG2 = 7,
  parameter int unsigned HOLD_CYC  = 80,
  parameter int unsigned PERIOD    = 200,
  parameter logic [31:0] SEED      = 32'h00003039
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [NUM_CH-1:0] intr_ack,
  output logic [NUM_CH-1:0] ext_intr,
  output logic [7:0]        fire_cnt,
  output logic              busy
);

  localparam longint unsigned DlyMax =
      64'(DLY_MIN) + (64'd1 << SPAN_LOG2) - 64'd1;
  localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("intr_stim_gen: NUM_CH must be in 1..8");
  end
  if (DlyMax > CntMax) begin : g_bad_dly
    $error("intr_stim_gen: DLY_MIN + 2**SPAN_LOG2 - 1 does not fit in CNT_W");
  end
  if (HOLD_CYC < 1 || 64'(HOLD_CYC) > CntMax + 64'd1) begin : g_bad_hold
    $error("intr_stim_gen: HOLD_CYC must be >= 1 and fit in CNT_W");
  end
  if (64'(PERIOD) > CntMax) begin : g_bad_period
    $error("intr_stim_gen: PERIOD does not fit in CNT_W");
  end

  logic [NUM_CH-1:0] ch_fire;
  logic [NUM_CH-1:0] ch_busy;
  logic [7:0]        fire_cnt_q, fire_cnt_d;
  logic [8:0]        fire_sum;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    intr_stim_ch #(
      .CNT_W    (CNT_W),
      .DLY_MIN  (DLY_MIN),
      .SPAN_LOG2(SPAN_LOG2),
      .HOLD_CYC (HOLD_CYC),
      .PERIOD   (PERIOD),
      .CH_SEED  (ch_seed(SEED, k))
    ) u_ch (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .enable_i(enable),
      .mode_i  (mode),
      .ack_i   (intr_ack[k]),
      .intr_o  (ext_intr[k]),
      .fire_o  (ch_fire[k]),
      .busy_o  (ch_busy[k])
    );
  end

  // Add this cycle's new rises to the running total, clamping at 8'hFF.
  always_comb begin
    fire_sum = {1'b0, fire_cnt_q};
    for (int k = 0; k < NUM_CH; k++) begin
      fire_sum = fire_sum + 9'(ch_fire[k]);
    end
    fire_cnt_d = fire_sum[8] ? 8'hFF : fire_sum[7:0];
  end

  // Fire counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fire_cnt_q <= 8'h00;
    end else begin
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign fire_cnt = fire_cnt_q;
  assign busy     = |ch_busy;

endmodule

// File: tb/tb_intr_stim_gen.sv
// Directed bench for intr_stim_gen with an edge-event scoreboard.
module tb_intr_stim_gen;

  localparam int DLY_A  = 20;
  localparam int HOLD_A = 8;
  localparam int PER_A  = 30;
  localparam int DLY_B  = 10;
  localparam int HOLD_B = 4;

  typedef struct packed {
    logic [23:0] cyc;
    logic [3:0]  rise;
    logic [3:0]  fall;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: four identical channels, no random span.
  logic       rst_a = 1'b0, en_a = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic [3:0] ack_a = 4'h0, ext_a, prev_a = 4'h0;
  logic [7:0] fire_a;
  logic       busy_a;

  // Instances B and C: random delays, different seeds, shared stimulus.
  logic       rst_b = 1'b0, en_b = 1'b0;
  logic [1:0] mode_b = 2'd2;
  logic [1:0] ack_b = 2'b00, ext_b, ext_c, prev_b = 2'b00, prev_c = 2'b00;
  logic [7:0] fire_b, fire_c;
  logic       busy_b, busy_c;

  intr_stim_gen #(
    .NUM_CH(4), .CNT_W(16), .DLY_MIN(DLY_A), .SPAN_LOG2(0), .HOLD_CYC(HOLD_A),
    .PERIOD(PER_A), .SEED(32'h00003039)
  ) dut_a (
    .clk(clk), .resetn(rst_a), .enable(en_a), .mode(mode_a), .intr_ack(ack_a),
    .ext_intr(ext_a), .fire_cnt(fire_a), .busy(busy_a)
  );

  intr_stim_gen #(
    .NUM_CH(2), .CNT_W(16), .DLY_MIN(DLY_B), .SPAN_LOG2(7), .HOLD_CYC(HOLD_B),
    .PERIOD(200), .SEED(32'd12345)
  ) dut_b (
    .clk(clk), .resetn(rst_b), .enable(en_b), .mode(mode_b), .intr_ack(ack_b),
    .ext_intr(ext_b), .fire_cnt(fire_b), .busy(busy_b)
  );

  intr_stim_gen #(
    .NUM_CH(2), .CNT_W(16), .DLY_MIN(DLY_B), .SPAN_LOG2(7), .HOLD_CYC(HOLD_B),
    .PERIOD(200), .SEED(32'd54321)
  ) dut_c (
    .clk(clk), .resetn(rst_b), .enable(en_b), .mode(mode_b), .intr_ack(ack_b),
    .ext_intr(ext_c), .fire_cnt(fire_c), .busy(busy_c)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  exp_t_q[$];
  int  rb0[$], rb1[$], rc0[$];
  logic mon_a = 1'b0;
  logic mon_b = 1'b0;

  function automatic ev_t mk_ev(input int c, input logic [3:0] r, input logic [3:0] f);
    ev_t e;
    e.cyc  = 24'(c);
    e.rise = r;
    e.fall = f;
    return e;
  endfunction

  // Sample edges on the falling clock, away from the active edge.
  always @(negedge clk) begin
    if (mon_a && (ext_a != prev_a)) obs_q.push_back(mk_ev(cyc, ext_a & ~prev_a, prev_a & ~ext_a));
    if (mon_b) begin
      if (ext_b[0] && !prev_b[0]) rb0.push_back(cyc);
      if (ext_b[1] && !prev_b[1]) rb1.push_back(cyc);
      if (ext_c[0] && !prev_c[0]) rc0.push_back(cyc);
    end
    prev_a <= ext_a;
    prev_b <= ext_b;
    prev_c <= ext_c;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_events(input string tag);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      chk(tag, o, e);
    end
    chk({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
    obs_q.delete();
  endtask

  // Reference LFSR, written from the polynomial x^32+x^22+x^2+x+1.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
    return n;
  endfunction

  function automatic logic [31:0] ref_seed(input logic [31:0] base, input int k);
    logic [31:0] s;
    s = base ^ (32'(k) * 32'h9E3779B9);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  // Push ten predicted rise cycles for mode 2, given reset release and enable cycles.
  task automatic predict(input logic [31:0] seed, input int rb, input int eb);
    logic [31:0] l;
    int n, p, t;
    l = seed;
    n = 0;
    p = eb + 1;
    for (int i = 0; i < 10; i++) begin
      while (n < p - 1 - rb) begin
        l = ref_step(l);
        n++;
      end
      t = p + DLY_B + int'(l[6:0]) + 1;
      exp_t_q.push_back(t);
      p = t + HOLD_B;
    end
  endtask

  task automatic cmp_rises(input string tag, input int which, output int got[10]);
    int o;
    for (int i = 0; i < 10; i++) begin
      o = -1;
      case (which)
        0: if (rb0.size() > 0) o = rb0.pop_front();
        1: if (rb1.size() > 0) o = rb1.pop_front();
        default: if (rc0.size() > 0) o = rc0.pop_front();
      endcase
      got[i] = o;
      chk(tag, o, exp_t_q.pop_front());
    end
  endtask

  initial begin
    int e, r, rb2;
    int run1_b0[10], run1_b1[10], run1_c0[10], run2_b0[10];
    int p, d;
    logic ok, differ;

    // Reset state
    wait_cyc(2);
    chk("rst_ext_a", ext_a, 4'h0);
    chk("rst_fire_a", fire_a, 8'h00);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_ext_b", ext_b, 2'b00);
    rst_a = 1'b1;

    // Random-repeat, run 1: compare against the reference LFSR
    wait_cyc(3);
    rst_b = 1'b1;
    mon_b = 1'b1;
    wait_cyc(8);
    en_b = 1'b1;
    predict(ref_seed(32'd12345, 0), 3, 8);
    predict(ref_seed(32'd12345, 1), 3, 8);
    predict(ref_seed(32'd54321, 0), 3, 8);
    wait_cyc(8 + 1500);
    cmp_rises("b0_rise", 0, run1_b0);
    cmp_rises("b1_rise", 1, run1_b1);
    cmp_rises("c0_rise", 2, run1_c0);
    p = 9;
    for (int i = 0; i < 10; i++) begin
      d = run1_b0[i] - p - 1;
      ok = (d >= DLY_B) && (d <= DLY_B + 127);
      chk("b0_dly_range", ok, 1'b1);
      p = run1_b0[i] + HOLD_B;
    end
    differ = 1'b0;
    for (int i = 0; i < 10; i++) if (run1_b0[i] != run1_c0[i]) differ = 1'b1;
    chk("seed_differs", differ, 1'b1);
    en_b = 1'b0;
    mon_b = 1'b0;
    wait_cyc(cyc + 2);
    chk("b_busy_off", busy_b, 1'b0);
    chk("c_busy_off", busy_c, 1'b0);

    // Random-repeat, run 2 after a fresh reset must repeat run 1
    rst_b = 1'b0;
    #1;
    chk("b_fire_async_rst", fire_b, 8'h00);
    chk("c_fire_async_rst", fire_c, 8'h00);
    rb0.delete();
    rb1.delete();
    rc0.delete();
    exp_t_q.delete();
    wait_cyc(cyc + 2);
    rst_b = 1'b1;
    rb2 = cyc;
    mon_b = 1'b1;
    wait_cyc(rb2 + 5);
    en_b = 1'b1;
    predict(ref_seed(32'd12345, 0), rb2, rb2 + 5);
    wait_cyc(rb2 + 5 + 1500);
    cmp_rises("b0_rerun", 0, run2_b0);
    for (int i = 0; i < 10; i++) chk("rerun_same", run2_b0[i] - rb2, run1_b0[i] - 3);
    en_b = 1'b0;
    mon_b = 1'b0;

    // One-shot: all four lines rise together, then DONE
    mon_a = 1'b1;
    obs_q.delete();
    e = cyc;
    mode_a = 2'd0;
    en_a = 1'b1;
    exp_q.push_back(mk_ev(e + 22, 4'hF, 4'h0));
    exp_q.push_back(mk_ev(e + 22 + HOLD_A, 4'h0, 4'hF));
    wait_cyc(e + 21);
    chk("os_fire_before", fire_a, 8'd0);
    chk("os_busy_wait", busy_a, 1'b1);
    wait_cyc(e + 22);
    chk("os_fire_jump", fire_a, 8'd4);
    chk("os_ext_high", ext_a, 4'hF);
    wait_cyc(e + 60);
    chk("os_done_busy", busy_a, 1'b0);
    chk("os_done_ext", ext_a, 4'h0);
    check_events("os_ev");
    en_a = 1'b0;
    wait_cyc(cyc + 2);

    // Periodic, with mode change and acks ignored, then enable abort mid-assert
    e = cyc;
    mode_a = 2'd1;
    en_a = 1'b1;
    r = e + 22;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_ev(r + i * (HOLD_A + PER_A + 1), 4'hF, 4'h0));
      if (i < 2) exp_q.push_back(mk_ev(r + i * (HOLD_A + PER_A + 1) + HOLD_A, 4'h0, 4'hF));
    end
    wait_cyc(r + 2);
    mode_a = 2'd0;
    ack_a = 4'hF;
    chk("per_fire_1", fire_a, 8'd8);
    wait_cyc(r + 3);
    ack_a = 4'h0;
    wait_cyc(r + 2 * (HOLD_A + PER_A + 1) + 3);
    en_a = 1'b0;
    exp_q.push_back(mk_ev(r + 2 * (HOLD_A + PER_A + 1) + 4, 4'h0, 4'hF));
    wait_cyc(cyc + 3);
    chk("per_fire_kept", fire_a, 8'd16);
    chk("per_abort_busy", busy_a, 1'b0);
    check_events("per_ev");

    // Hold-until-ack
    e = cyc;
    mode_a = 2'd3;
    en_a = 1'b1;
    r = e + 22;
    wait_cyc(e + 5);
    ack_a = 4'hF;
    wait_cyc(e + 6);
    ack_a = 4'h0;
    wait_cyc(r);
    ack_a = 4'b0010;
    wait_cyc(r + 1);
    ack_a = 4'h0;
    wait_cyc(r + 10);
    ack_a = 4'b0100;
    wait_cyc(r + 11);
    ack_a = 4'h0;
    wait_cyc(r + 30);
    ack_a = 4'b1001;
    wait_cyc(r + 31);
    ack_a = 4'h0;
    wait_cyc(r + 55);
    en_a = 1'b0;
    exp_q.push_back(mk_ev(r, 4'hF, 4'h0));
    exp_q.push_back(mk_ev(r + 1, 4'h0, 4'b0010));
    exp_q.push_back(mk_ev(r + 11, 4'h0, 4'b0100));
    exp_q.push_back(mk_ev(r + 22, 4'b0010, 4'h0));
    exp_q.push_back(mk_ev(r + 31, 4'h0, 4'b1001));
    exp_q.push_back(mk_ev(r + 32, 4'b0100, 4'h0));
    exp_q.push_back(mk_ev(r + 52, 4'b1001, 4'h0));
    exp_q.push_back(mk_ev(r + 56, 4'h0, 4'hF));
    wait_cyc(r + 58);
    chk("ack_fire", fire_a, 8'd24);
    check_events("ack_ev");
    mon_a = 1'b0;
    wait_cyc(cyc + 2);

    // Random-repeat with zero span: saturate the fire counter
    e = cyc;
    mode_a = 2'd2;
    en_a = 1'b1;
    wait_cyc(e + 22);
    chk("sat_fire_first", fire_a, 8'd28);
    wait_cyc(e + 22 + 29 * 56);
    chk("sat_fire_252", fire_a, 8'd252);
    wait_cyc(e + 1700);
    chk("sat_fire_ff", fire_a, 8'hFF);
    en_a = 1'b0;
    wait_cyc(cyc + 2);

    // Asynchronous reset while asserted
    e = cyc;
    mode_a = 2'd0;
    en_a = 1'b1;
    wait_cyc(e + 24);
    chk("ar_ext_before", ext_a, 4'hF);
    #2;
    rst_a = 1'b0;
    #1;
    chk("ar_ext", ext_a, 4'h0);
    chk("ar_fire", fire_a, 8'h00);
    chk("ar_busy", busy_a, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_stim_gen.md
Name: intr_stim_gen

Overview:
- Parametrised, synthesizable external-interrupt stimulus generator for core-level benches and FPGA bring-up.
- Drives NUM_CH interrupt lines into top-level ext_intr inputs. Each line asserts after a pseudo-random, LFSR-derived delay and is held for a fixed time or until acknowledged.
- Replaces ad-hoc initial-block pokes with a seedable, repeatable, multi-channel source that supports one-shot, periodic, random-repeat and hold-until-ack modes.

Parameters:
- NUM_CH, 2: number of independent interrupt channels (1..8).
- CNT_W, 16: width of delay/hold counters.
- DLY_MIN, 10: minimum assert delay, in cycles.
- SPAN_LOG2, 7: random delay span. Delay = DLY_MIN + (lfsr[SPAN_LOG2-1:0]).
- HOLD_CYC, 80: assert duration, in cycles, for non-ack modes (>=1).
- PERIOD, 200: fixed re-arm delay for periodic mode.
- SEED, 32'h00003039: base LFSR seed. Channel k seed = SEED ^ (k * 32'h9E3779B9); a zero result is forced to 32'h1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  level; 0 parks all channels in IDLE with outputs low
- mode  in  2  0 one-shot, 1 periodic, 2 random-repeat, 3 hold-until-ack; sampled on IDLE->WAIT
- intr_ack  in  NUM_CH  per-channel acknowledge pulse (mode 3 only)
- ext_intr  out  NUM_CH  registered interrupt lines
- fire_cnt  out  8  total assertions across all channels, saturating at 8'hFF
- busy  out  1  OR of (channel state != IDLE && != DONE)

Behaviour:
- Reset: ext_intr=0, fire_cnt=0, busy=0, all channels IDLE, counters 0, LFSRs loaded with their per-channel seeds.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances every cycle regardless of state, so the sequence is deterministic from reset for a given SEED.
- Per-channel FSM, states IDLE, WAIT, ASSERT, DONE:
  - IDLE: when enable=1, latch mode and load cnt with the delay, then go to WAIT next cycle. Delay is DLY_MIN + lfsr[SPAN_LOG2-1:0] for modes 0/2/3, DLY_MIN for mode 1 first shot.
  - WAIT: cnt decrements each cycle. When cnt==0, go to ASSERT and set ext_intr[k]=1 in the same registered update, so the line is high in the cycle after cnt reaches 0. fire_cnt increments that same cycle.
  - ASSERT, modes 0-2: hold for exactly HOLD_CYC cycles, then drop ext_intr[k].
    - Mode 0: go to DONE.
    - Mode 1: reload PERIOD and go to WAIT.
    - Mode 2: reload a random delay and go to WAIT.
  - ASSERT, mode 3: hold until intr_ack[k]=1, drop ext_intr[k] the next cycle, then reload a random delay and go to WAIT.
  - DONE: sticky. Exits to IDLE only when enable=0.
- Latency:
  - DLY_MIN=0 with lfsr bits=0 gives ext_intr high 2 cycles after enable rises (IDLE->WAIT, WAIT->ASSERT).
  - In general, first assertion = enable edge + 2 + delay cycles.
- enable deassert mid-operation: every channel goes to IDLE on the next edge and ext_intr drops that cycle. fire_cnt is retained. LFSRs are not reseeded.
- Ack handling:
  - intr_ack[k] is ignored outside ASSERT and in modes 0-2.
  - Ack arriving in the same cycle the line rises is honoured: the line stays high exactly 1 cycle.
- Simultaneous fires on several channels in one cycle: fire_cnt adds popcount(new rises), saturating at 255.
- mode changes while not in IDLE are ignored until the next IDLE->WAIT transition.
- Delay sum width: DLY_MIN + 2^SPAN_LOG2 - 1 must fit in CNT_W. Elaboration-time check errors otherwise.
- Async reset mid-assert: ext_intr drops immediately, without waiting for a clock edge.

Decomposition:
- Package intr_stim_pkg:
  - mode encodings MODE_ONESHOT/MODE_PERIODIC/MODE_RANDOM/MODE_ACK
  - FSM state encodings ST_IDLE/ST_WAIT/ST_ASSERT/ST_DONE
  - LFSR tap constant LFSR_TAPS=32'h80200003
  - golden-ratio seed spreader constant
- Sub-module intr_stim_ch: one channel (LFSR, counter, FSM). Instantiated NUM_CH times via generate.
- Top: contains only the popcount/saturating fire counter and busy OR.

Test Plan:
- NUM_CH=1, DLY_MIN=100, SPAN_LOG2=0, HOLD_CYC=80, mode 0, enable at cycle 5 -> ext_intr rises at cycle 107, falls at 187, fire_cnt=1, channel in DONE, busy=0.
- Mode 1, PERIOD=200, SPAN_LOG2=0 -> rising edges at t0, t0+281, t0+562 (80 high + 200 WAIT + 1). fire_cnt increments by 1 at each edge.
- Mode 3: ack pulsed 30 cycles after the rise -> line high exactly 31 cycles. Ack issued in IDLE/WAIT -> no effect on ext_intr or state.
- NUM_CH=4, SPAN_LOG2=0, mode 0 -> all 4 lines rise in the same cycle and fire_cnt jumps 0->4. Mode 2 run past 255 fires -> fire_cnt holds at 8'hFF.
- Reseed determinism, mode 2, SEED=12345: two runs give identical ext_intr edge times over 10 fires. SEED=54321 gives a different sequence. Every delay lies in [DLY_MIN, DLY_MIN+127].
- Abort cases:
  - Deassert enable mid-ASSERT -> line low the next cycle, state IDLE, fire_cnt retained.
  - Assert resetn=0 mid-WAIT -> outputs low asynchronously, fire_cnt=0.
